// File: rtl/pmod_dac_pkg.sv
// Shared definitions for the PMOD DAC serial link (driver and receiver).
// Frame layout: [31:28] unused, [27:24] cmd, [23:20] addr, [19:8] data, [7:0] unused.
package pmod_dac_pkg;

  localparam logic [3:0] CMD_WR_IN      = 4'h0;
  localparam logic [3:0] CMD_UPD        = 4'h1;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'h2;
  localparam logic [3:0] CMD_WR_UPD     = 4'h3;
  localparam logic [3:0] ADDR_ALL       = 4'hF;

  localparam int FIELD_W  = 4;
  localparam int CMD_LSB  = 24;
  localparam int ADDR_LSB = 20;
  localparam int DATA_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE,
    ST_ERR
  } rx_state_t;

endpackage

// File: rtl/pmod_dac_spi_receiver_if.sv
// PMOD DAC pin bundle; the driver owns the pins, the receiver observes them.
interface pmod_dac_spi_receiver_if;
  logic dac_cs_n;
  logic dac_sclk;
  logic dac_din;
  logic dac_ldac_n;

  modport master (output dac_cs_n, output dac_sclk, output dac_din, output dac_ldac_n);
  modport slave  (input  dac_cs_n, input  dac_sclk, input  dac_din, input  dac_ldac_n);
endinterface

// File: rtl/pmod_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall pulses taken
// from the synchronised value (edge visible 2 clk after the pin moves).
module pmod_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= INIT;
      sync <= INIT;
      prev <= INIT;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/pmod_dac_spi_receiver.sv
// Receiver/mirror for the PMOD DAC serial link: deserialises 32-bit frames and
// keeps input/DAC registers. Optional LDAC support under PMOD_DAC_RX_LDAC_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for cs_n falling edge
// ST_SHIFT  | shifting din on sclk falling edges until cs_n rises
// ST_DECODE | one cycle: execute command, pulse frame_valid
// ST_ERR    | one cycle: bad bit count, pulse frame_error, set sticky flag
module pmod_dac_spi_receiver
  import pmod_dac_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  pmod_dac_spi_receiver_if.slave   pins,
  output logic                     frame_valid,
  output logic [3:0]               frame_cmd,
  output logic [3:0]               frame_addr,
  output logic [DATA_W-1:0]        frame_data,
  output logic                     frame_error,
  output logic [NUM_CH*DATA_W-1:0] dac_values,
  output logic [3:0]               leds
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic din_lvl, din_rise, din_fall;
  logic ldac_lvl, ldac_rise, ldac_fall;

  pmod_sync_edge #(.INIT(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .pin(pins.dac_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  pmod_sync_edge #(.INIT(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(pins.dac_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  pmod_sync_edge #(.INIT(1'b0)) u_sync_din (
    .clk(clk), .rst(rst), .pin(pins.dac_din),
    .level(din_lvl), .rise(din_rise), .fall(din_fall));
  pmod_sync_edge #(.INIT(1'b1)) u_sync_ldac (
    .clk(clk), .rst(rst), .pin(pins.dac_ldac_n),
    .level(ldac_lvl), .rise(ldac_rise), .fall(ldac_fall));

  rx_state_t               state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   sr;
  logic                    sticky_error;
  logic                    valid_tog;
  logic                    ldac_seen;
  logic [DATA_W-1:0]       in_reg  [NUM_CH];
  logic [DATA_W-1:0]       dac_reg [NUM_CH];
  logic [DATA_W-1:0]       in_nxt  [NUM_CH];
  logic [DATA_W-1:0]       dac_nxt [NUM_CH];

  logic [3:0]        fr_cmd;
  logic [3:0]        fr_addr;
  logic [DATA_W-1:0] fr_data;
  logic              addr_ok;
  logic              sel;

  assign fr_cmd  = sr[CMD_LSB +: FIELD_W];
  assign fr_addr = sr[ADDR_LSB +: FIELD_W];
  assign fr_data = sr[DATA_LSB +: DATA_W];
  assign addr_ok = (fr_addr == ADDR_ALL) || (int'(fr_addr) < NUM_CH);

  // Command effect first, then LDAC copy, so a coincident LDAC sees the new input.
  always_comb begin
    in_nxt  = in_reg;
    dac_nxt = dac_reg;
    sel     = 1'b0;
    if (state == ST_DECODE && addr_ok) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sel = (fr_addr == ADDR_ALL) || (int'(fr_addr) == ch);
        if (sel) begin
          case (fr_cmd)
            CMD_WR_IN, CMD_WR_UPD_ALL: in_nxt[ch] = fr_data;
            CMD_UPD:                   dac_nxt[ch] = in_reg[ch];
            CMD_WR_UPD: begin
              in_nxt[ch]  = fr_data;
              dac_nxt[ch] = fr_data;
            end
            default: ;
          endcase
        end
      end
      if (fr_cmd == CMD_WR_UPD_ALL) begin
        for (int ch = 0; ch < NUM_CH; ch++) dac_nxt[ch] = in_nxt[ch];
      end
    end
`ifdef PMOD_DAC_RX_LDAC_EN
    if (ldac_fall) begin
      for (int ch = 0; ch < NUM_CH; ch++) dac_nxt[ch] = in_nxt[ch];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      sr           <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      frame_cmd    <= '0;
      frame_addr   <= '0;
      frame_data   <= '0;
      sticky_error <= 1'b0;
      valid_tog    <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        in_reg[ch]  <= '0;
        dac_reg[ch] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      in_reg      <= in_nxt;
      dac_reg     <= dac_nxt;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            sr      <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state <= (bit_cnt == CNT_FULL) ? ST_DECODE : ST_ERR;
          end else if (sclk_fall) begin
            sr <= {sr[FRAME_BITS-2:0], din_lvl};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_DECODE, ST_ERR: begin
          if (state == ST_DECODE) begin
            frame_valid <= 1'b1;
            frame_cmd   <= fr_cmd;
            frame_addr  <= fr_addr;
            frame_data  <= fr_data;
            valid_tog   <= ~valid_tog;
          end else begin
            frame_error  <= 1'b1;
            sticky_error <= 1'b1;
          end
          // A new frame may already be starting in this same cycle.
          if (cs_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            sr      <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PMOD_DAC_RX_LDAC_EN
  always_ff @(posedge clk) begin
    if (!rst)           ldac_seen <= 1'b0;
    else if (ldac_fall) ldac_seen <= 1'b1;
  end
`else
  assign ldac_seen = 1'b0;
`endif

  always_comb begin
    dac_values = '0;
    for (int ch = 0; ch < NUM_CH; ch++) dac_values[ch*DATA_W +: DATA_W] = dac_reg[ch];
  end

  assign leds = {sticky_error, valid_tog, ~cs_lvl, ldac_seen};

  logic unused_sig;
  assign unused_sig = ^{sclk_lvl, sclk_rise, din_rise, din_fall, ldac_lvl, ldac_rise, ldac_fall,
                        sr[FRAME_BITS-1 -: FIELD_W], sr[DATA_LSB-1:0]};

endmodule

// File: tb/tb_pmod_dac_spi_receiver.sv
// Directed bench for pmod_dac_spi_receiver: table of frames plus hand-written
// back-to-back, reset-mid-frame and LDAC sequences.
module tb_pmod_dac_spi_receiver;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pmod_dac_spi_receiver_if pins();

  logic                     frame_valid;
  logic [3:0]               frame_cmd;
  logic [3:0]               frame_addr;
  logic [DATA_W-1:0]        frame_data;
  logic                     frame_error;
  logic [NUM_CH*DATA_W-1:0] dac_values;
  logic [3:0]               leds;

  pmod_dac_spi_receiver #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_BITS(32)) dut (
    .clk(clk), .rst(rst), .pins(pins),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_addr(frame_addr),
    .frame_data(frame_data), .frame_error(frame_error),
    .dac_values(dac_values), .leds(leds));

  int errors = 0;
  int checks = 0;
  int nvalid = 0;
  int nerr   = 0;

  always @(negedge clk) begin
    if (frame_valid) nvalid++;
    if (frame_error) nerr++;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] setch(input logic [95:0] v, input int n, input logic [11:0] x);
    logic [95:0] m;
    m = 96'hFFF << (n * 12);
    return (v & ~m) | (96'(x) << (n * 12));
  endfunction

  task automatic shift_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i < 32) pins.dac_din = w[31 - i];
      else        pins.dac_din = 1'b0;
      repeat (4) @(negedge clk);
      pins.dac_sclk = 1'b0;
      repeat (4) @(negedge clk);
      pins.dac_sclk = 1'b1;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    pins.dac_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raise cs_n and wait (bounded) for the frame_valid/frame_error pulse.
  task automatic finish_frame(output bit got_v, output bit got_e, output int lat);
    repeat (2) @(negedge clk);
    pins.dac_cs_n = 1'b1;
    got_v = 1'b0;
    got_e = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (frame_valid || frame_error) begin
        got_v = frame_valid;
        got_e = frame_error;
        lat   = c;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] word;
    int          nbits;
    bit          exp_err;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic [95:0] dac;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [95:0] e;
    logic [95:0] all_f;
    bit          got_v, got_e;
    int          lat;
    bit          exp_sticky;
    bit          exp_tog;
    int          v0, e0;

    pins.dac_cs_n   = 1'b1;
    pins.dac_sclk   = 1'b1;
    pins.dac_din    = 1'b0;
    pins.dac_ldac_n = 1'b1;

    all_f = {8{12'hFFF}};
    e = setch('0, 3, 12'hABC);
    vecs[0] = '{32'h033ABC00, 32, 1'b0, 4'h3, 4'h3, 12'hABC, e};
    vecs[1] = '{32'h00112300, 32, 1'b0, 4'h0, 4'h1, 12'h123, e};
    e = setch(e, 1, 12'h123);
    vecs[2] = '{32'h01100000, 32, 1'b0, 4'h1, 4'h1, 12'h000, e};
    vecs[3] = '{32'h0A5A5A5A, 31, 1'b1, 4'h0, 4'h0, 12'h000, e};
    vecs[4] = '{32'h02FFFF00, 32, 1'b0, 4'h2, 4'hF, 12'hFFF, all_f};
    vecs[5] = '{32'h03977700, 32, 1'b0, 4'h3, 4'h9, 12'h777, all_f};
    vecs[6] = '{32'h05011100, 32, 1'b0, 4'h5, 4'h0, 12'h111, all_f};
    vecs[7] = '{32'h00F0AA00, 32, 1'b0, 4'h0, 4'hF, 12'h0AA, all_f};
    e = setch(all_f, 2, 12'h0AA);
    vecs[8] = '{32'h01200000, 32, 1'b0, 4'h1, 4'h2, 12'h000, e};
    vecs[9] = '{32'h033ABC00, 33, 1'b1, 4'h0, 4'h0, 12'h000, e};
    e = setch(e, 0, 12'h5A5);
    vecs[10] = '{32'hF305A5CD, 32, 1'b0, 4'h3, 4'h0, 12'h5A5, e};

    repeat (4) @(negedge clk);
    check("reset_dac", 96'(dac_values), '0);
    check("reset_leds", 96'(leds), '0);
    check("reset_fields", 96'({frame_cmd, frame_addr, frame_data}), '0);
    check("reset_pulses", 96'({frame_valid, frame_error}), '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    exp_sticky = 1'b0;
    exp_tog    = 1'b0;
    for (int i = 0; i < 11; i++) begin
      start_frame();
      shift_bits(vecs[i].word, vecs[i].nbits);
      finish_frame(got_v, got_e, lat);
      check($sformatf("v%0d_kind", i), 96'({got_v, got_e}), vecs[i].exp_err ? 96'b01 : 96'b10);
      check($sformatf("v%0d_latency", i), 96'(lat), 96'd4);
      if (vecs[i].exp_err) exp_sticky = 1'b1;
      else begin
        exp_tog = ~exp_tog;
        check($sformatf("v%0d_fields", i), 96'({frame_cmd, frame_addr, frame_data}),
              96'({vecs[i].cmd, vecs[i].addr, vecs[i].data}));
      end
      check($sformatf("v%0d_dac", i), 96'(dac_values), vecs[i].dac);
      check($sformatf("v%0d_leds", i), 96'(leds[3:2]), 96'({exp_sticky, exp_tog}));
    end

    // Back-to-back: cs_n high for one clk, so the next cs fall lands in DECODE.
    e  = vecs[10].dac;
    v0 = nvalid;
    e0 = nerr;
    start_frame();
    shift_bits(32'h03712300, 32);
    repeat (2) @(negedge clk);
    pins.dac_cs_n = 1'b1;
    @(negedge clk);
    pins.dac_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(32'h03444400, 32);
    finish_frame(got_v, got_e, lat);
    e = setch(setch(e, 7, 12'h123), 4, 12'h444);
    check("b2b_valid_count", 96'(nvalid - v0), 96'd2);
    check("b2b_error_count", 96'(nerr - e0), 96'd0);
    check("b2b_latency", 96'(lat), 96'd4);
    check("b2b_dac", 96'(dac_values), e);
    check("b2b_fields", 96'({frame_cmd, frame_addr, frame_data}), 96'({4'h3, 4'h4, 12'h444}));

    // Reset in the middle of a frame.
    e0 = nerr;
    start_frame();
    shift_bits(32'h033ABC00, 16);
    @(negedge clk);
    check("cs_active", 96'(leds[1]), 96'd1);
    rst = 1'b0;
    pins.dac_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_dac", 96'(dac_values), '0);
    check("midrst_leds", 96'(leds), '0);
    check("midrst_fields", 96'({frame_cmd, frame_addr, frame_data}), '0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_error", 96'(nerr - e0), 96'd0);
    start_frame();
    shift_bits(32'h03632100, 32);
    finish_frame(got_v, got_e, lat);
    check("postrst_kind", 96'({got_v, got_e}), 96'b10);
    check("postrst_dac", 96'(dac_values), setch('0, 6, 12'h321));

    // LDAC strobe after writing only the input register of ch5.
    start_frame();
    shift_bits(32'h00555500, 32);
    finish_frame(got_v, got_e, lat);
    check("ldac_pre_dac", 96'(dac_values), setch('0, 6, 12'h321));
    @(negedge clk);
    pins.dac_ldac_n = 1'b0;
    repeat (4) @(negedge clk);
    pins.dac_ldac_n = 1'b1;
    repeat (4) @(negedge clk);
`ifdef PMOD_DAC_RX_LDAC_EN
    check("ldac_dac", 96'(dac_values), setch(setch('0, 6, 12'h321), 5, 12'h555));
    check("ldac_led", 96'(leds[0]), 96'd1);
`else
    check("ldac_dac", 96'(dac_values), setch('0, 6, 12'h321));
    check("ldac_led", 96'(leds[0]), 96'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
